// File: rtl/picture_ycbcr_window_bin_pkg.sv
// picture_ycbcr_window_bin_pkg: channel encodings, BT.601 Q8 coefficients and clamp helper.
package picture_ycbcr_window_bin_pkg;
    typedef enum logic [1:0] {CH_Y = 2'd0, CH_CB = 2'd1, CH_CR = 2'd2, CH_Y_ALT = 2'd3} ch_e;
    // Rows: Y, Cb, Cr; columns: R, G, B; Q8 fixed point.
    localparam int COEF [3][3] = '{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}};
    localparam int FRAC = 8;
    function automatic int clamp_u(input int v, input int max_v);
        return (v < 0) ? 0 : ((v > max_v) ? max_v : v);
    endfunction
endpackage

// File: rtl/picture_ycbcr_window_bin_rgb2ycbcr.sv
// picture_ycbcr_window_bin_rgb2ycbcr: 3-clk RGB to YCbCr444 converter with matching sync delay.
module picture_ycbcr_window_bin_rgb2ycbcr
    import picture_ycbcr_window_bin_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        sync,
    input  logic [DATA_W-1:0] red,
    input  logic [DATA_W-1:0] green,
    input  logic [DATA_W-1:0] blue,
    output logic [2:0]        sync_dly,
    output logic [DATA_W-1:0] y,
    output logic [DATA_W-1:0] cb,
    output logic [DATA_W-1:0] cr
);
    localparam int SW = DATA_W + 10;
    localparam int OFS = 1 << (DATA_W - 1);
    localparam int MAX_V = (1 << DATA_W) - 1;

    logic [DATA_W-1:0]    px [3];
    logic signed [SW-1:0] prod [3][3];
    logic signed [SW-1:0] sum [3];
    logic [DATA_W-1:0]    ycc [3];
    logic [2:0]           sync_pipe [3];

    assign px = '{red, green, blue};

    // Arithmetic shift floors negative sums; chroma rows get the mid-scale offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                sum[i] <= '0;
                ycc[i] <= '0;
                sync_pipe[i] <= '0;
                for (int j = 0; j < 3; j++) prod[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) prod[i][j] <= $signed({10'b0, px[j]}) * SW'(COEF[i][j]);
                sum[i] <= prod[i][0] + prod[i][1] + prod[i][2];
                ycc[i] <= DATA_W'(clamp_u(int'(sum[i] >>> FRAC) + ((i == 0) ? 0 : OFS), MAX_V));
            end
            sync_pipe <= '{sync, sync_pipe[0], sync_pipe[1]};
        end
    end

    assign y = ycc[0];
    assign cb = ycc[1];
    assign cr = ycc[2];
    assign sync_dly = sync_pipe[2];
endmodule

// File: rtl/picture_ycbcr_window_bin.sv
// picture_ycbcr_window_bin: RGB->YCbCr, frame-synchronised band threshold on a selected channel,
// 1-bit mask output and per-frame foreground pixel count.
module picture_ycbcr_window_bin
    import picture_ycbcr_window_bin_pkg::*;
#(
    parameter int         DATA_W   = 8,
    parameter int         CNT_W    = 20,
    parameter logic [1:0] DEF_CH   = 2'd1,
    parameter int         DEF_LOW  = 0,
    parameter int         DEF_HIGH = 150
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_frame_clken,
    input  logic [DATA_W-1:0] per_img_red,
    input  logic [DATA_W-1:0] per_img_green,
    input  logic [DATA_W-1:0] per_img_blue,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_ch_sel,
    input  logic [DATA_W-1:0] cfg_th_low,
    input  logic [DATA_W-1:0] cfg_th_high,
    input  logic              cfg_invert,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_frame_clken,
    output logic              post_img_Bit,
    output logic [DATA_W-1:0] post_img_sel,
    output logic [CNT_W-1:0]  frame_fg_count,
    output logic              frame_fg_valid
);
    localparam int CW = 2 + 2 * DATA_W + 1;
    localparam logic [CW-1:0] CFG_DEF = {DEF_CH, DATA_W'(DEF_LOW), DATA_W'(DEF_HIGH), 1'b0};

    logic [CW-1:0]     pend, act, cfg_new;
    logic [CW-1:0]     cfg_pipe [3];
    logic              vs_prev, vs_rise;
    logic [2:0]        sync_dly;
    logic [DATA_W-1:0] y, cb, cr, sel, lo, hi;
    ch_e               ch;
    logic              inv, in_band, mask;
    logic [CNT_W-1:0]  acc;
    logic              seen, post_vs_prev, post_rise, fg_hit;

    picture_ycbcr_window_bin_rgb2ycbcr #(.DATA_W(DATA_W)) u_conv (
        .clk      (clk),
        .rst      (rst),
        .sync     ({per_frame_vsync, per_frame_href, per_frame_clken}),
        .red      (per_img_red),
        .green    (per_img_green),
        .blue     (per_img_blue),
        .sync_dly (sync_dly),
        .y        (y),
        .cb       (cb),
        .cr       (cr)
    );

    assign cfg_new = {cfg_ch_sel, cfg_th_low, cfg_th_high, cfg_invert};
    assign vs_rise = per_frame_vsync & ~vs_prev;

    // The config in force is captured alongside each pixel so a frame never sees a mid-frame change.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= CFG_DEF;
            act <= CFG_DEF;
            vs_prev <= 1'b0;
            cfg_pipe <= '{'0, '0, '0};
        end else begin
            vs_prev <= per_frame_vsync;
            if (cfg_valid) pend <= cfg_new;
            if (vs_rise) act <= cfg_valid ? cfg_new : pend;
            cfg_pipe <= '{act, cfg_pipe[0], cfg_pipe[1]};
        end
    end

    assign ch = ch_e'(cfg_pipe[2][CW-1 -: 2]);
    assign lo = cfg_pipe[2][2*DATA_W -: DATA_W];
    assign hi = cfg_pipe[2][DATA_W -: DATA_W];
    assign inv = cfg_pipe[2][0];
    assign sel = (ch == CH_CB) ? cb : (ch == CH_CR) ? cr : y;
    assign in_band = (lo <= hi) ? (sel >= lo && sel <= hi) : (sel >= lo || sel <= hi);
    assign mask = in_band ^ inv;

    always_ff @(posedge clk) begin
        if (rst) begin
            {post_frame_vsync, post_frame_href, post_frame_clken} <= 3'b000;
            post_img_Bit <= 1'b0;
            post_img_sel <= '0;
        end else begin
            {post_frame_vsync, post_frame_href, post_frame_clken} <= sync_dly;
            if (sync_dly[1] & sync_dly[0]) begin
                post_img_Bit <= mask;
                post_img_sel <= sel;
            end
        end
    end

    assign fg_hit = post_frame_href & post_frame_clken & post_img_Bit;
    assign post_rise = post_frame_vsync & ~post_vs_prev;

    // The first frame after reset is partial, so it only arms the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            seen <= 1'b0;
            post_vs_prev <= 1'b0;
            frame_fg_count <= '0;
            frame_fg_valid <= 1'b0;
        end else begin
            post_vs_prev <= post_frame_vsync;
            frame_fg_valid <= post_rise & seen;
            if (post_rise) begin
                if (seen) frame_fg_count <= acc;
                acc <= CNT_W'(fg_hit);
                seen <= 1'b1;
            end else if (fg_hit && !(&acc)) begin
                acc <= acc + CNT_W'(1);
            end
        end
    end
endmodule
